// File: rtl/nco_pkg.sv
// nco_pkg: state encoding and default word width shared by the NCO and its sweep controller.
package nco_pkg;
    localparam int DEFAULT_STEP_SIZE = 16;
    typedef enum logic [2:0] {IDLE, UP, UP_LAST, DOWN, DOWN_LAST} sweep_state_t;
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: counts 0..dwell while enabled and flags the terminal count so the caller can advance.
module dwell_timer #(
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic                   tc
);
    logic [DWELL_WIDTH-1:0] cnt;
    assign tc = cnt == dwell;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= tc ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/chirp_sweeper.sv
// chirp_sweeper: stepped linear frequency sweep driving the NCO step word, with dwell per frequency.
// Define CHIRP_SWEEPER_TRIANGLE_EN to ramp back down to f_start after reaching f_stop.
module chirp_sweeper
    import nco_pkg::*;
#(
    parameter int STEP_SIZE   = DEFAULT_STEP_SIZE,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [STEP_SIZE-1:0]   f_start,
    input  logic [STEP_SIZE-1:0]   f_stop,
    input  logic [STEP_SIZE-1:0]   f_inc,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic [STEP_SIZE-1:0]   step,
    output logic                   busy,
    output logic                   done
);
    sweep_state_t           state;
    logic [STEP_SIZE-1:0]   f_start_q, f_stop_q, f_inc_q;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic                   expire, ramp_ok, up_hit;
    logic [STEP_SIZE:0]     up_nxt;
    // One extra bit so the increment can never wrap past f_stop.
    assign up_nxt  = {1'b0, step} + {1'b0, f_inc_q};
    assign up_hit  = up_nxt >= {1'b0, f_stop_q};
    assign ramp_ok = (f_stop > f_start) && (f_inc != '0);
`ifdef CHIRP_SWEEPER_TRIANGLE_EN
    logic ramp_q, turn_hit, dn_hit;
    logic [STEP_SIZE:0] floor_w;
    assign floor_w  = {1'b0, f_start_q} + {1'b0, f_inc_q};
    assign ramp_q   = (f_stop_q > f_start_q) && (f_inc_q != '0);
    assign turn_hit = {1'b0, f_stop_q} <= floor_w;
    assign dn_hit   = {1'b0, step} <= floor_w;
`endif
    dwell_timer #(.DWELL_WIDTH(DWELL_WIDTH)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (abort || state == IDLE),
        .en   (state != IDLE),
        .dwell(dwell_q),
        .tc   (expire)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            step      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            f_start_q <= '0;
            f_stop_q  <= '0;
            f_inc_q   <= '0;
            dwell_q   <= '0;
        end else if (abort) begin
            state <= IDLE;
            step  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    f_start_q <= f_start;
                    f_stop_q  <= f_stop;
                    f_inc_q   <= f_inc;
                    dwell_q   <= dwell;
                    step      <= f_start;
                    busy      <= 1'b1;
                    state     <= ramp_ok ? UP : UP_LAST;
                end
                UP: if (expire) begin
                    step  <= up_hit ? f_stop_q : up_nxt[STEP_SIZE-1:0];
                    state <= up_hit ? UP_LAST : UP;
                end
                UP_LAST: if (expire) begin
`ifdef CHIRP_SWEEPER_TRIANGLE_EN
                    if (!ramp_q) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        step  <= turn_hit ? f_start_q : f_stop_q - f_inc_q;
                        state <= turn_hit ? DOWN_LAST : DOWN;
                    end
`else
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
`endif
                end
`ifdef CHIRP_SWEEPER_TRIANGLE_EN
                DOWN: if (expire) begin
                    step  <= dn_hit ? f_start_q : step - f_inc_q;
                    state <= dn_hit ? DOWN_LAST : DOWN;
                end
                DOWN_LAST: if (expire) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chirp_sweeper.sv
// tb_chirp_sweeper: directed checks of sweep sequences, clamping, degenerate sweeps, abort and reset.
module tb_chirp_sweeper;
    logic        clk, rst, start, abort;
    logic [15:0] f_start, f_stop, f_inc, dwell, step;
    logic        busy, done;
    int          n_cmp = 0, n_bad = 0;
    int          seq[$];

    chirp_sweeper dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .f_start(f_start), .f_stop(f_stop), .f_inc(f_inc), .dwell(dwell),
        .step(step), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int fs, input int fp, input int fi, input int dw);
        f_start = 16'(fs);
        f_stop  = 16'(fp);
        f_inc   = 16'(fi);
        dwell   = 16'(dw);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Walks seq, each value held dw+1 cycles; optionally pokes start mid-sweep.
    task automatic expect_sweep(input string tag, input int dw, input int poke_at);
        int k = 0;
        foreach (seq[i])
            for (int c = 0; c <= dw; c++) begin
                chk({tag, ".step"}, 32'(step), seq[i]);
                chk({tag, ".busy"}, 32'(busy), 1);
                chk({tag, ".done"}, 32'(done), 0);
                if (k == poke_at) begin
                    start = 1'b1; f_start = 7; f_stop = 9; f_inc = 1; dwell = 0;
                end
                k++;
                tick();
                start = 1'b0;
            end
        chk({tag, ".end_busy"}, 32'(busy), 0);
        chk({tag, ".end_done"}, 32'(done), 1);
        chk({tag, ".end_step"}, 32'(step), seq[seq.size()-1]);
        tick();
        chk({tag, ".done_clr"}, 32'(done), 0);
        chk({tag, ".hold_step"}, 32'(step), seq[seq.size()-1]);
    endtask

    task automatic basic_seq();
`ifdef CHIRP_SWEEPER_TRIANGLE_EN
        seq = '{100, 110, 120, 130, 120, 110, 100};
`else
        seq = '{100, 110, 120, 130};
`endif
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        f_start = 0; f_stop = 0; f_inc = 0; dwell = 0;
        #2;
        chk("rst.step", 32'(step), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        tick();
        rst = 1'b1;
        tick();

        basic_seq();
        do_start(100, 130, 10, 2);
        expect_sweep("basic", 2, -1);

`ifdef CHIRP_SWEEPER_TRIANGLE_EN
        seq = '{100, 110, 120, 125, 115, 105, 100};
`else
        seq = '{100, 110, 120, 125};
`endif
        do_start(100, 125, 10, 0);
        expect_sweep("clamp", 0, -1);

        seq = '{100};
        do_start(100, 90, 10, 1);
        expect_sweep("degen_stop", 1, -1);
        do_start(100, 130, 0, 1);
        expect_sweep("degen_inc", 1, -1);

        basic_seq();
        do_start(100, 130, 10, 2);
        expect_sweep("busy_start", 2, 4);

        do_start(100, 130, 10, 2);
        for (int c = 0; c < 4; c++) begin
            chk("abort.pre_step", 32'(step), c < 3 ? 100 : 110);
            if (c < 3) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort.step", 32'(step), 0);
        chk("abort.busy", 32'(busy), 0);
        chk("abort.done", 32'(done), 0);
        for (int c = 0; c < 12; c++) begin
            chk("abort.no_done", 32'(done), 0);
            tick();
        end

        f_start = 100; f_stop = 130; f_inc = 10; dwell = 2;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_start.busy", 32'(busy), 0);
        chk("abort_start.step", 32'(step), 0);

        do_start(100, 130, 10, 2);
        tick(); tick(); tick();
        chk("rst_mid.pre_step", 32'(step), 110);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid.step", 32'(step), 0);
        chk("rst_mid.busy", 32'(busy), 0);
        chk("rst_mid.done", 32'(done), 0);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid.idle_busy", 32'(busy), 0);
        basic_seq();
        do_start(100, 130, 10, 2);
        expect_sweep("after_rst", 2, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
